// File: rtl/aes_pkg.sv
// Shared AES-128 constants and round-function helpers for the iterative round sequencer.
package aes_pkg;

  localparam int unsigned NR        = 10;
  localparam int unsigned KEY_W     = 128;
  localparam logic [7:0]  RCON_INIT = 8'h01;

  typedef enum logic [1:0] {StIdle, StRound, StDone} fsm_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes are ordered row 0 at the MSB.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte s[r][c] sits at bits [127-8*(4c+r) -: 8]; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// AES-128 on-the-fly key expansion: derives the next round key from the current one.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] roundKey,
  input  logic [7:0]   rcon,
  output logic [127:0] nextKey
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, t;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = roundKey[127:96];
  assign w1 = roundKey[95:64];
  assign w2 = roundKey[63:32];
  assign w3 = roundKey[31:0];

  assign rot = {w3[23:0], w3[31:24]};
  assign t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
             ^ {rcon, 24'h0};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign nextKey = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption core: one round per clock with the key expanded alongside.
module aes_round_sequencer
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inValid,
  output logic         inReady,
  input  logic [127:0] plainText,
  input  logic [127:0] cipherKey,
  output logic         outValid,
  input  logic         outReady,
  output logic [127:0] cipherText,
  output logic         busy
);

  localparam logic [3:0] LastRound = 4'(NR);

  fsm_e         fsm_q, fsm_d;
  logic [127:0] data_q, data_d;
  logic [127:0] key_q, key_d;
  logic [127:0] ct_q, ct_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;

  logic [127:0] next_key;
  logic [127:0] sub_out, shift_out, mix_out, round_out;
  logic         last_round;

  aes_key_step u_key_step (
    .roundKey (key_q),
    .rcon     (rcon_q),
    .nextKey  (next_key)
  );

  assign last_round = (round_q == LastRound);

  always_comb begin
    sub_out = '0;
    mix_out = '0;
    for (int i = 0; i < 16; i++) begin
      sub_out[127-8*i -: 8] = sbox(data_q[127-8*i -: 8]);
    end
    shift_out = shift_rows(sub_out);
    for (int c = 0; c < 4; c++) begin
      mix_out[127-32*c -: 32] = mix_column(shift_out[127-32*c -: 32]);
    end
    // The final round skips MixColumns.
    round_out = (last_round ? shift_out : mix_out) ^ next_key;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= StIdle;
      data_q  <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      round_q <= '0;
      rcon_q  <= RCON_INIT;
    end else begin
      fsm_q   <= fsm_d;
      data_q  <= data_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    data_d  = data_q;
    key_d   = key_q;
    ct_d    = ct_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    unique case (fsm_q)
      StIdle: begin
        if (inValid) begin
          fsm_d   = StRound;
          data_d  = plainText ^ cipherKey;
          key_d   = cipherKey;
          round_d = 4'd1;
          rcon_d  = RCON_INIT;
        end
      end
      StRound: begin
        data_d = round_out;
        key_d  = next_key;
        rcon_d = xtime(rcon_q);
        if (last_round) begin
          fsm_d = StDone;
          ct_d  = round_out;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      StDone: begin
        if (outReady) fsm_d = StIdle;
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_comb begin
    inReady  = (fsm_q == StIdle);
    outValid = (fsm_q == StDone);
    busy     = (fsm_q == StRound) || (fsm_q == StDone);
  end

  assign cipherText = ct_q;

endmodule
